// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream arbiter/mux.
// Holds the arbitration FSM states and the channel-ID width helper.
package stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request search starting at ptr and wrapping N-1 -> 0.
// Purely combinational; the lowest offset from ptr wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    always_comb begin
        int j;
        j          = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        // Walk offsets from farthest to nearest so the nearest valid request overwrites.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                gnt_onehot    = '0;
                gnt_onehot[j] = 1'b1;
                gnt_idx       = IW'(j);
                gnt_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// Merges NUM_CH valid/ready streams into one registered output stream, round-robin,
// optionally holding the grant for a whole packet; 1-cycle latency, output stalls hold all sources.
module stream_arb_mux
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int PKT_MODE   = 1,
    localparam int CH_W      = ch_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            s_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]            s_last,
    output logic [NUM_CH-1:0]            s_ready,
    output logic                         m_valid,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_last,
    output logic [CH_W-1:0]              m_ch,
    input  logic                         m_ready
);

    arb_state_e             state, state_nxt;
    logic [CH_W-1:0]        ptr, ptr_nxt;
    logic [CH_W-1:0]        lock_ch, lock_nxt;
    logic [CH_W-1:0]        rr_idx, gnt;
    logic [NUM_CH-1:0]      rr_onehot;
    logic                   rr_valid, gnt_valid;
    logic                   load, accept, acc_last;
    logic [DATA_WIDTH-1:0]  acc_data;

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (CH_W)
    ) u_rr (
        .req        (s_valid),
        .ptr        (ptr),
        .gnt_onehot (rr_onehot),
        .gnt_idx    (rr_idx),
        .gnt_valid  (rr_valid)
    );

    // Locked grant ignores s_valid entirely, so s_ready never depends on other channels.
    always_comb begin
        load      = !m_valid || m_ready;
        gnt       = rr_idx;
        gnt_valid = rr_valid;
        s_ready   = '0;
        if (state == LOCKED) begin
            gnt       = lock_ch;
            gnt_valid = 1'b1;
            if (!rst && load) begin
                s_ready[lock_ch] = 1'b1;
            end
        end else if (!rst && load) begin
            s_ready = rr_onehot;
        end
        accept   = gnt_valid && s_ready[gnt] && s_valid[gnt];
        acc_data = s_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
        acc_last = s_last[gnt];
    end

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_ch;
        ptr_nxt   = ptr;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (PKT_MODE != 0 && !acc_last) begin
                        state_nxt = LOCKED;
                        lock_nxt  = gnt;
                    end
                end
                LOCKED: begin
                    if (acc_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            // Pointer advances only when the grant ends, so a packet never yields mid-way.
            if (PKT_MODE == 0 || acc_last) begin
                ptr_nxt = (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            lock_ch <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_ch    <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lock_ch <= lock_nxt;
            if (load) begin
                m_valid <= accept;
                if (accept) begin
                    m_data <= acc_data;
                    m_last <= acc_last;
                    m_ch   <= gnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench: beat-mode RR and backpressure, packet-mode lock/gap/reset, and single-channel pipe.
module tb_stream_arb_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: beat mode
    logic [3:0]  a_s_valid, a_s_last, a_s_ready;
    logic [31:0] a_s_data;
    logic        a_m_valid, a_m_last, a_m_ready;
    logic [7:0]  a_m_data;
    logic [1:0]  a_m_ch;

    // Instance B: packet mode
    logic [3:0]  b_s_valid, b_s_last, b_s_ready;
    logic [31:0] b_s_data;
    logic        b_m_valid, b_m_last, b_m_ready;
    logic [7:0]  b_m_data;
    logic [1:0]  b_m_ch;

    // Instance C: one channel
    logic [0:0]  c_s_valid, c_s_last, c_s_ready;
    logic [7:0]  c_s_data;
    logic        c_m_valid, c_m_last, c_m_ready;
    logic [7:0]  c_m_data;
    logic [0:0]  c_m_ch;

    stream_arb_mux #(.DATA_WIDTH(8), .NUM_CH(4), .PKT_MODE(0)) dut_a (
        .clk(clk), .rst(rst),
        .s_valid(a_s_valid), .s_data(a_s_data), .s_last(a_s_last), .s_ready(a_s_ready),
        .m_valid(a_m_valid), .m_data(a_m_data), .m_last(a_m_last), .m_ch(a_m_ch),
        .m_ready(a_m_ready)
    );

    stream_arb_mux #(.DATA_WIDTH(8), .NUM_CH(4), .PKT_MODE(1)) dut_b (
        .clk(clk), .rst(rst),
        .s_valid(b_s_valid), .s_data(b_s_data), .s_last(b_s_last), .s_ready(b_s_ready),
        .m_valid(b_m_valid), .m_data(b_m_data), .m_last(b_m_last), .m_ch(b_m_ch),
        .m_ready(b_m_ready)
    );

    stream_arb_mux #(.DATA_WIDTH(8), .NUM_CH(1), .PKT_MODE(1)) dut_c (
        .clk(clk), .rst(rst),
        .s_valid(c_s_valid), .s_data(c_s_data), .s_last(c_s_last), .s_ready(c_s_ready),
        .m_valid(c_m_valid), .m_data(c_m_data), .m_last(c_m_last), .m_ch(c_m_ch),
        .m_ready(c_m_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic [1:0] ch, input logic [7:0] dat,
                         input logic last);
        chk({tag, ".vld"},  32'(b_m_valid), 32'd1);
        chk({tag, ".ch"},   32'(b_m_ch),    32'(ch));
        chk({tag, ".dat"},  32'(b_m_data),  32'(dat));
        chk({tag, ".last"}, 32'(b_m_last),  32'(last));
    endtask

    initial begin
        rst       = 1'b1;
        a_s_valid = 4'hF; a_s_last = 4'h0; a_s_data = 32'hA3A2A1A0; a_m_ready = 1'b1;
        b_s_valid = 4'hF; b_s_last = 4'h0; b_s_data = 32'h0;        b_m_ready = 1'b1;
        c_s_valid = 1'b1; c_s_last = 1'b0; c_s_data = 8'h0;         c_m_ready = 1'b1;

        // Reset state with every source valid
        tick;
        chk("rst.a_m_valid", 32'(a_m_valid), 32'd0);
        chk("rst.a_m_data",  32'(a_m_data),  32'd0);
        chk("rst.a_m_ch",    32'(a_m_ch),    32'd0);
        chk("rst.a_m_last",  32'(a_m_last),  32'd0);
        chk("rst.a_s_ready", 32'(a_s_ready), 32'd0);
        chk("rst.b_s_ready", 32'(b_s_ready), 32'd0);
        chk("rst.c_m_valid", 32'(c_m_valid), 32'd0);
        tick;
        rst       = 1'b0;
        b_s_valid = 4'h0;
        c_s_valid = 1'b0;

        // Beat round-robin: A0,A1,A2,A3,A0
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("rr.m_valid", 32'(a_m_valid), 32'd1);
            chk("rr.m_data",  32'(a_m_data),  32'hA0 + 32'(k % 4));
            chk("rr.m_ch",    32'(a_m_ch),    32'(k % 4));
            chk("rr.s_ready", 32'(a_s_ready), 32'(1 << ((k + 1) % 4)));
        end

        // Backpressure: 0x5C held for 5 stalled cycles, then consumed once
        a_s_data = 32'h5C5C5C5C;
        tick;
        chk("bp.cap_data", 32'(a_m_data), 32'h5C);
        chk("bp.cap_ch",   32'(a_m_ch),   32'd1);
        a_m_ready = 1'b0;
        #1;
        chk("bp.s_ready_now", 32'(a_s_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("bp.m_valid", 32'(a_m_valid), 32'd1);
            chk("bp.m_data",  32'(a_m_data),  32'h5C);
            chk("bp.m_ch",    32'(a_m_ch),    32'd1);
            chk("bp.s_ready", 32'(a_s_ready), 32'd0);
        end
        a_m_ready = 1'b1;
        a_s_valid = 4'h0;
        tick;
        chk("bp.drain_vld", 32'(a_m_valid), 32'd0);

        // Single-beat packet from ch1 advances ptr to 2
        b_s_valid = 4'b0010; b_s_last = 4'b0010; b_s_data = 32'h00001100;
        tick;
        chk_b("single", 2'd1, 8'h11, 1'b1);
        chk("single.s_ready", 32'(b_s_ready), 32'b0010);

        // Packet lock: ch2 sends 3 beats while ch0/ch1 are valid
        b_s_valid = 4'b0111; b_s_last = 4'b0000; b_s_data = 32'h00210201;
        tick;
        chk_b("lock.b1", 2'd2, 8'h21, 1'b0);
        b_s_data = 32'h00220201;
        #1;
        chk("lock.s_ready", 32'(b_s_ready), 32'b0100);
        tick;
        chk_b("lock.b2", 2'd2, 8'h22, 1'b0);
        b_s_data = 32'h00230201; b_s_last = 4'b0111;
        tick;
        chk_b("lock.b3", 2'd2, 8'h23, 1'b1);
        b_s_valid = 4'b0011;
        tick;
        chk_b("lock.next0", 2'd0, 8'h01, 1'b1);
        tick;
        chk_b("lock.next1", 2'd1, 8'h02, 1'b1);

        // Locked gap: ch1 locked and idle for 3 cycles while ch0 waits
        b_s_valid = 4'b0010; b_s_last = 4'b0000; b_s_data = 32'h0000310F;
        tick;
        chk_b("gap.start", 2'd1, 8'h31, 1'b0);
        b_s_valid = 4'b0001; b_s_last = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("gap.m_valid", 32'(b_m_valid), 32'd0);
            chk("gap.s_ready", 32'(b_s_ready), 32'b0010);
        end
        b_s_valid = 4'b0011; b_s_last = 4'b0011; b_s_data = 32'h0000320F;
        tick;
        chk_b("gap.end", 2'd1, 8'h32, 1'b1);
        tick;
        chk_b("gap.ch0", 2'd0, 8'h0F, 1'b1);

        // Reset in the middle of a ch3 packet
        b_s_valid = 4'b1000; b_s_last = 4'b0000; b_s_data = 32'h41000000;
        tick;
        chk_b("mrst.b1", 2'd3, 8'h41, 1'b0);
        b_s_valid = 4'b1111; b_s_data = 32'h42030201;
        #1;
        chk("mrst.s_ready_pre", 32'(b_s_ready), 32'b1000);
        rst = 1'b1;
        #1;
        chk("mrst.m_valid", 32'(b_m_valid), 32'd0);
        chk("mrst.m_data",  32'(b_m_data),  32'd0);
        chk("mrst.m_ch",    32'(b_m_ch),    32'd0);
        chk("mrst.m_last",  32'(b_m_last),  32'd0);
        chk("mrst.s_ready", 32'(b_s_ready), 32'd0);
        tick;
        rst = 1'b0;
        tick;
        chk_b("mrst.after", 2'd0, 8'h01, 1'b0);

        // Single channel: plain pipeline register with stall hold
        c_s_valid = 1'b1; c_s_last = 1'b0; c_s_data = 8'h77;
        tick;
        chk("one.m_valid", 32'(c_m_valid), 32'd1);
        chk("one.m_data",  32'(c_m_data),  32'h77);
        chk("one.m_ch",    32'(c_m_ch),    32'd0);
        chk("one.s_ready", 32'(c_s_ready), 32'd1);
        c_m_ready = 1'b0; c_s_data = 8'h78;
        tick;
        chk("one.hold",    32'(c_m_data),  32'h77);
        chk("one.stall",   32'(c_s_ready), 32'd0);
        c_m_ready = 1'b1;
        tick;
        chk("one.next",    32'(c_m_data),  32'h78);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
